// File: rtl/nf10_input_arbiter_rr_if.sv
// nf10_input_arbiter_rr_if: one AXI4-Stream link; master drives the payload, slave drives tready
interface nf10_input_arbiter_rr_if #(
  parameter int DW = 256,
  parameter int UW = 128
);
  logic [DW-1:0] tdata;
  logic [DW/8-1:0] tstrb;
  logic [UW-1:0] tuser;
  logic tvalid;
  logic tready;
  logic tlast;
  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/nf10_input_arbiter_rr.sv
// nf10_input_arbiter_rr: packet round-robin merge of five AXI4-Stream ports through fall-through FIFOs.
// Optional NF10_ARB_SRC_PORT_STAMP_EN stamps the source port one-hot into tuser[23:16] of each first beat.
module nf10_input_arbiter_rr #(
  parameter int C_AXIS_DATA_WIDTH = 256,
  parameter int C_USER_WIDTH = 128,
  parameter int NUM_QUEUES = 5,
  parameter int IN_FIFO_DEPTH_BITS = 4
) (
  input logic axi_aclk,
  input logic axi_reset,
  nf10_input_arbiter_rr_if.slave s_axis_0,
  nf10_input_arbiter_rr_if.slave s_axis_1,
  nf10_input_arbiter_rr_if.slave s_axis_2,
  nf10_input_arbiter_rr_if.slave s_axis_3,
  nf10_input_arbiter_rr_if.slave s_axis_4,
  nf10_input_arbiter_rr_if.master m_axis
);
  localparam int SW = C_AXIS_DATA_WIDTH / 8;
  localparam int W = 1 + SW + C_AXIS_DATA_WIDTH + C_USER_WIDTH;
  localparam int DEPTH = 1 << IN_FIFO_DEPTH_BITS;
  localparam int CW = IN_FIFO_DEPTH_BITS + 1;
  typedef enum logic {IDLE, WR_PKT} state_t;
  state_t r_state, w_nxt_state;
  logic [2:0] r_cur, w_nxt_cur;
  logic [3:0] w_sum;
  logic [W-1:0] w_din [NUM_QUEUES];
  logic [W-1:0] w_head [NUM_QUEUES];
  logic [W-1:0] w_hd;
  logic [NUM_QUEUES-1:0] w_vld, w_rdy, w_wr, w_rd, w_empty, w_nfull;
  logic w_hs;
  logic [C_USER_WIDTH-1:0] w_tuser;
  // FIFO word layout: {tlast, tstrb, tdata, tuser}
  assign w_din[0] = {s_axis_0.tlast, s_axis_0.tstrb, s_axis_0.tdata, s_axis_0.tuser};
  assign w_din[1] = {s_axis_1.tlast, s_axis_1.tstrb, s_axis_1.tdata, s_axis_1.tuser};
  assign w_din[2] = {s_axis_2.tlast, s_axis_2.tstrb, s_axis_2.tdata, s_axis_2.tuser};
  assign w_din[3] = {s_axis_3.tlast, s_axis_3.tstrb, s_axis_3.tdata, s_axis_3.tuser};
  assign w_din[4] = {s_axis_4.tlast, s_axis_4.tstrb, s_axis_4.tdata, s_axis_4.tuser};
  assign w_vld = {s_axis_4.tvalid, s_axis_3.tvalid, s_axis_2.tvalid, s_axis_1.tvalid, s_axis_0.tvalid};
  assign w_rdy = ~w_nfull & {NUM_QUEUES{~axi_reset}};
  assign w_wr = w_vld & w_rdy;
  assign s_axis_0.tready = w_rdy[0];
  assign s_axis_1.tready = w_rdy[1];
  assign s_axis_2.tready = w_rdy[2];
  assign s_axis_3.tready = w_rdy[3];
  assign s_axis_4.tready = w_rdy[4];
  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_fifo
    logic [W-1:0] r_mem [DEPTH];
    logic [IN_FIFO_DEPTH_BITS-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;
    always_ff @(posedge axi_aclk)
      if (w_wr[q]) r_mem[r_wp] <= w_din[q];
    always_ff @(posedge axi_aclk or posedge axi_reset)
      if (axi_reset) begin
        r_wp <= '0;
        r_rp <= '0;
        r_cnt <= '0;
      end else begin
        r_wp <= r_wp + IN_FIFO_DEPTH_BITS'(w_wr[q]);
        r_rp <= r_rp + IN_FIFO_DEPTH_BITS'(w_rd[q]);
        r_cnt <= r_cnt + CW'(w_wr[q]) - CW'(w_rd[q]);
      end
    assign w_head[q] = r_mem[r_rp];
    assign w_empty[q] = r_cnt == '0;
    assign w_nfull[q] = r_cnt >= CW'(DEPTH - 1);
  end
  always_ff @(posedge axi_aclk or posedge axi_reset)
    if (axi_reset) begin
      r_state <= IDLE;
      r_cur <= 3'd4;
    end else begin
      r_state <= w_nxt_state;
      r_cur <= w_nxt_cur;
    end
  assign w_hd = w_head[r_cur];
  assign m_axis.tvalid = (r_state == WR_PKT) & ~w_empty[r_cur];
  assign w_hs = m_axis.tvalid & m_axis.tready;
  assign w_rd = w_hs ? NUM_QUEUES'(1) << r_cur : '0;
  // Scan downward so the nearest non-empty port after r_cur is the last, winning assignment
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cur = r_cur;
    w_sum = '0;
    if (r_state == IDLE) begin
      for (int k = NUM_QUEUES; k >= 1; k--) begin
        w_sum = {1'b0, r_cur} + 4'(k);
        w_sum = (w_sum >= 4'(NUM_QUEUES)) ? w_sum - 4'(NUM_QUEUES) : w_sum;
        if (!w_empty[w_sum[2:0]]) begin
          w_nxt_cur = w_sum[2:0];
          w_nxt_state = WR_PKT;
        end
      end
    end else if (w_hs && w_hd[W-1]) begin
      w_nxt_state = IDLE;
    end
  end
  assign m_axis.tlast = w_hd[W-1];
  assign m_axis.tstrb = w_hd[W-2 -: SW];
  assign m_axis.tdata = w_hd[C_USER_WIDTH +: C_AXIS_DATA_WIDTH];
  assign m_axis.tuser = w_tuser;
`ifdef NF10_ARB_SRC_PORT_STAMP_EN
  logic r_sop;
  always_ff @(posedge axi_aclk or posedge axi_reset)
    if (axi_reset) r_sop <= 1'b1;
    else if (w_hs) r_sop <= w_hd[W-1];
  always_comb begin
    w_tuser = w_hd[C_USER_WIDTH-1:0];
    if (r_sop) w_tuser[23:16] = (r_cur == 3'd4) ? 8'h02 : 8'h01 << {r_cur, 1'b0};
  end
`else
  assign w_tuser = w_hd[C_USER_WIDTH-1:0];
`endif
endmodule

// File: tb/tb_nf10_input_arbiter_rr.sv
// tb_nf10_input_arbiter_rr: directed scenarios plus random traffic checked against a packet-queue model
module tb_nf10_input_arbiter_rr;
  localparam int DW = 256;
  localparam int UW = 128;
  localparam int SW = DW / 8;
`ifdef NF10_ARB_SRC_PORT_STAMP_EN
  localparam logic [7:0] STAMP4 = 8'h02;
`else
  localparam logic [7:0] STAMP4 = 8'h00;
`endif
  typedef struct packed {
    logic last;
    logic [SW-1:0] strb;
    logic [DW-1:0] data;
    logic [UW-1:0] user;
  } beat_t;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  nf10_input_arbiter_rr_if #(.DW(DW), .UW(UW)) s_if[5] ();
  nf10_input_arbiter_rr_if #(.DW(DW), .UW(UW)) m_if ();
  logic [DW-1:0] d_data [5];
  logic [SW-1:0] d_strb [5];
  logic [UW-1:0] d_user [5];
  logic [4:0] d_valid, d_last, s_rdy, acc;
  logic m_ready;
  for (genvar g = 0; g < 5; g++) begin : g_drv
    assign s_if[g].tdata = d_data[g];
    assign s_if[g].tstrb = d_strb[g];
    assign s_if[g].tuser = d_user[g];
    assign s_if[g].tvalid = d_valid[g];
    assign s_if[g].tlast = d_last[g];
    assign s_rdy[g] = s_if[g].tready;
  end
  assign m_if.tready = m_ready;
  nf10_input_arbiter_rr dut (
    .axi_aclk(clk), .axi_reset(rst),
    .s_axis_0(s_if[0]), .s_axis_1(s_if[1]), .s_axis_2(s_if[2]),
    .s_axis_3(s_if[3]), .s_axis_4(s_if[4]), .m_axis(m_if)
  );
  beat_t mq [5][$];
  int cur, busy, first, cyc, nout, checks, fails;
  int maxocc [5];
  int left [5];
  int src_log [$];
  int fhs [$];
  int lhs [$];
  task automatic chk(input string n, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  function automatic logic [UW-1:0] stamp(input logic [UW-1:0] u, input int p);
`ifdef NF10_ARB_SRC_PORT_STAMP_EN
    u[23:16] = (p == 4) ? 8'h02 : 8'(1 << (2 * p));
`endif
    return u;
  endfunction
  function automatic int pend();
    int s = busy;
    for (int i = 0; i < 5; i++) s += mq[i].size();
    return s;
  endfunction
  // Model: each port is a queue of accepted beats; a whole packet is taken from the port picked
  // round-robin during an idle cycle, and one idle cycle separates packets.
  task automatic monitor();
    beat_t e, b;
    int nxt, found;
    forever begin
      @(negedge clk);
      cyc++;
      acc = '0;
      if (rst) begin
        chk("reset_tvalid", m_if.tvalid, 0);
        chk("reset_tready", s_rdy, 0);
        for (int i = 0; i < 5; i++) mq[i].delete();
        busy = 0;
        cur = 4;
        first = 1;
      end else begin
        for (int i = 0; i < 5; i++) begin
          chk($sformatf("tready%0d", i), s_rdy[i], mq[i].size() < 15);
          if (mq[i].size() > maxocc[i]) maxocc[i] = mq[i].size();
        end
        if (busy == 0) begin
          chk("idle_tvalid", m_if.tvalid, 0);
          found = 0;
          nxt = cur;
          for (int k = 5; k >= 1; k--)
            if (mq[(cur + k) % 5].size() != 0) begin
              nxt = (cur + k) % 5;
              found = 1;
            end
          if (found != 0) begin
            cur = nxt;
            busy = 1;
            first = 1;
          end
        end else begin
          chk($sformatf("tvalid_p%0d", cur), m_if.tvalid, mq[cur].size() != 0);
          if (m_if.tvalid && mq[cur].size() != 0) begin
            e = mq[cur][0];
            if (first != 0) e.user = stamp(e.user, cur);
            chk($sformatf("beat_p%0d", cur), {m_if.tlast, m_if.tstrb, m_if.tdata, m_if.tuser}, e);
            if (m_ready) begin
              void'(mq[cur].pop_front());
              nout++;
              if (first != 0) fhs.push_back(cyc);
              first = 0;
              if (e.last) begin
                busy = 0;
                first = 1;
                src_log.push_back(cur);
                lhs.push_back(cyc);
              end
            end
          end
        end
        for (int i = 0; i < 5; i++)
          if (d_valid[i] && s_rdy[i]) begin
            b = {d_last[i], d_strb[i], d_data[i], d_user[i]};
            mq[i].push_back(b);
            acc[i] = 1'b1;
          end
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int p, input logic [DW-1:0] d, input logic [UW-1:0] u, input logic l);
    int n = 0;
    d_valid[p] = 1'b1;
    d_data[p] = d;
    d_user[p] = u;
    d_last[p] = l;
    d_strb[p] = $urandom;
    do begin
      tick();
      n++;
    end while (!acc[p] && n < 500);
    chk($sformatf("send_accept_p%0d", p), acc[p], 1);
  endtask
  task automatic drain();
    int n = 0;
    while (pend() != 0 && n < 3000) begin
      tick();
      n++;
    end
    chk("drain", pend(), 0);
  endtask
  task automatic do_reset();
    d_valid = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic rnd_step(input bit start_ok);
    for (int i = 0; i < 5; i++) begin
      if (acc[i]) left[i]--;
      if (!d_valid[i] || acc[i]) begin
        if (left[i] == 0 && start_ok && $urandom_range(3) == 0) left[i] = $urandom_range(1, 24);
        if (left[i] != 0 && $urandom_range(7) != 0) begin
          d_valid[i] = 1'b1;
          d_data[i] = {8{$urandom}};
          d_strb[i] = $urandom;
          d_user[i] = {4{$urandom}};
          d_last[i] = (left[i] == 1);
        end else d_valid[i] = 1'b0;
      end
    end
  endtask
  initial begin
    logic [UW-1:0] u;
    logic [DW-1:0] d1, d2, d3;
    int base, fb, lb, nb, n, tog;
    d_valid = '0;
    d_last = '0;
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d_data[i] = '0;
      d_strb[i] = '0;
      d_user[i] = '0;
      maxocc[i] = 0;
      left[i] = 0;
    end
    cur = 4;
    busy = 0;
    first = 1;
    fork
      monitor();
    join_none
    repeat (3) tick();
    rst = 1'b0;
    // 3-beat packet on port 2: valid two cycles after the first write, contiguous beats
    base = src_log.size();
    u = {4{$urandom}};
    u[23:16] = 8'h10;
    d1 = {8{$urandom}};
    d2 = {8{$urandom}};
    d3 = {8{$urandom}};
    send(2, d1, u, 0);
    chk("t1_valid_cycle1", m_if.tvalid, 0);
    send(2, d2, {4{$urandom}}, 0);
    chk("t1_valid_cycle2", m_if.tvalid, 1);
    chk("t1_data1", m_if.tdata, d1);
    chk("t1_user", m_if.tuser, u);
    send(2, d3, {4{$urandom}}, 1);
    d_valid[2] = 1'b0;
    chk("t1_data2", {m_if.tvalid, m_if.tlast, m_if.tdata}, {2'b10, d2});
    tick();
    chk("t1_data3", {m_if.tvalid, m_if.tlast, m_if.tdata}, {2'b11, d3});
    drain();
    chk("t1_npkt", src_log.size() - base, 1);
    if (src_log.size() > base) chk("t1_src", src_log[base], 2);
    // Ports 0, 1, 4 loaded together after reset: served 0, 1, 4 with one idle cycle between
    do_reset();
    base = src_log.size();
    fb = fhs.size();
    lb = lhs.size();
    m_ready = 1'b0;
    foreach (d1[i]) d1[i] = 1'b0;
    for (int p = 0; p < 5; p++)
      if (p == 0 || p == 1 || p == 4) begin
        send(p, {8{$urandom}}, {4{$urandom}}, 0);
        send(p, {8{$urandom}}, {4{$urandom}}, 1);
        d_valid[p] = 1'b0;
      end
    m_ready = 1'b1;
    drain();
    chk("t2_npkt", src_log.size() - base, 3);
    if (src_log.size() >= base + 3) begin
      chk("t2_order0", src_log[base], 0);
      chk("t2_order1", src_log[base + 1], 1);
      chk("t2_order2", src_log[base + 2], 4);
    end
    if (fhs.size() >= fb + 3 && lhs.size() >= lb + 2) begin
      chk("t2_gap1", fhs[fb + 1] - lhs[lb], 2);
      chk("t2_gap2", fhs[fb + 2] - lhs[lb + 1], 2);
    end
    // 40-beat packet on port 3 with toggling downstream ready fills the FIFO to 15
    do_reset();
    maxocc[3] = 0;
    nb = nout;
    tog = 1;
    fork
      while (tog != 0) begin
        tick();
        m_ready = ~m_ready;
      end
    join_none
    for (int b = 0; b < 40; b++) send(3, {8{$urandom}}, {4{$urandom}}, b == 39);
    d_valid[3] = 1'b0;
    drain();
    tog = 0;
    tick();
    tick();
    m_ready = 1'b1;
    chk("t3_maxocc", maxocc[3], 15);
    chk("t3_beats", nout - nb, 40);
    // Port 1 stalls mid-packet while port 2 holds a complete packet
    do_reset();
    base = src_log.size();
    send(1, {8{$urandom}}, {4{$urandom}}, 0);
    d_valid[1] = 1'b0;
    send(2, {8{$urandom}}, {4{$urandom}}, 0);
    send(2, {8{$urandom}}, {4{$urandom}}, 0);
    send(2, {8{$urandom}}, {4{$urandom}}, 1);
    d_valid[2] = 1'b0;
    repeat (5) tick();
    chk("t4_stall", m_if.tvalid, 0);
    send(1, {8{$urandom}}, {4{$urandom}}, 1);
    d_valid[1] = 1'b0;
    drain();
    chk("t4_npkt", src_log.size() - base, 2);
    if (src_log.size() >= base + 2) begin
      chk("t4_order0", src_log[base], 1);
      chk("t4_order1", src_log[base + 1], 2);
    end
    // Reset asserted mid-packet from port 0, then a clean packet
    do_reset();
    send(0, {8{$urandom}}, {4{$urandom}}, 0);
    send(0, {8{$urandom}}, {4{$urandom}}, 0);
    d_valid[0] = 1'b0;
    chk("t5_inflight", m_if.tvalid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_tvalid", m_if.tvalid, 0);
    chk("t5_rst_tready", s_rdy, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("t5_ready_after", {m_if.tvalid, s_rdy}, 6'b011111);
    base = src_log.size();
    nb = nout;
    tick();
    send(0, {8{$urandom}}, {4{$urandom}}, 0);
    send(0, {8{$urandom}}, {4{$urandom}}, 1);
    d_valid[0] = 1'b0;
    drain();
    chk("t5_npkt", src_log.size() - base, 1);
    chk("t5_beats", nout - nb, 2);
    if (src_log.size() > base) chk("t5_src", src_log[base], 0);
    // Source-port stamp on a port 4 packet
    do_reset();
    u = {4{$urandom}};
    u[23:16] = 8'h00;
    send(4, {8{$urandom}}, u, 1);
    d_valid[4] = 1'b0;
    n = 0;
    while (!m_if.tvalid && n < 20) begin
      tick();
      n++;
    end
    chk("t6_valid", m_if.tvalid, 1);
    chk("t6_stamp", m_if.tuser[23:16], STAMP4);
    chk("t6_user_rest", {m_if.tuser[UW-1:24], m_if.tuser[15:0]}, {u[UW-1:24], u[15:0]});
    drain();
    // Random traffic on all ports with random downstream backpressure
    for (int c = 0; c < 3000; c++) begin
      rnd_step(1'b1);
      m_ready = ($urandom_range(3) != 0);
      tick();
    end
    n = 0;
    while ((left[0] + left[1] + left[2] + left[3] + left[4]) != 0 && n < 5000) begin
      rnd_step(1'b0);
      m_ready = 1'b1;
      tick();
      n++;
    end
    chk("rnd_sources_done", left[0] + left[1] + left[2] + left[3] + left[4], 0);
    d_valid = '0;
    m_ready = 1'b1;
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
